// File: rtl/alu_decode_exec_if.sv
// Request/result bundle between an ALU decode/execute block and its neighbours.
// Carries the valid/ready request side and the valid/ready result side.
// slave = the ALU block, master = the producer/consumer around it.
interface alu_decode_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_ctrl;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_illegal;

    modport slave (
        input  in_valid, alu_op, funct3, funct7_5, op_a, op_b, out_ready,
        output in_ready, out_valid, out_ctrl, out_result, out_zero, out_illegal
    );

    modport master (
        output in_valid, alu_op, funct3, funct7_5, op_a, op_b, out_ready,
        input  in_ready, out_valid, out_ctrl, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_decode_exec.sv
// ALU control decode (ALUop/funct3/funct7_5) followed by execute, two register stages.
// Latency: 2 cycles from request accept to registered result, one request per cycle.
// Backpressure: out_ready low holds S2; S1 then fills and in_ready drops after two accepts.
module alu_decode_exec #(
    parameter int XLEN     = 32,
    parameter bit SHIFT_EN = 1'b1
) (
    input logic              clk,
    input logic              res,
    alu_decode_exec_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SLL  = 4'b0100;
    localparam logic [3:0] CTRL_SRL  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SRA  = 4'b0111;
    localparam logic [3:0] CTRL_SLT  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic            illegal;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } s1_t;

    // stage state
    logic            s1_vld;
    s1_t             s1_q;
    logic            s2_vld;
    logic [3:0]      s2_ctrl;
    logic [XLEN-1:0] s2_result;
    logic            s2_zero;
    logic            s2_illegal;

    // decode / execute nets
    logic [3:0]      dec_ctrl;
    logic            dec_illegal;
    logic            dec_shift;
    logic [XLEN-1:0] exe_result;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;

    logic            in_acc;
    logic            s2_load;

    // S2 accepts from S1 when empty or draining this cycle; S1 frees up when it advances
    assign s2_load      = s1_vld && (!s2_vld || bus.out_ready);
    assign bus.in_ready = !s1_vld || s2_load;
    assign in_acc       = bus.in_valid && bus.in_ready;

    assign bus.out_valid   = s2_vld;
    assign bus.out_ctrl    = s2_ctrl;
    assign bus.out_result  = s2_result;
    assign bus.out_zero    = s2_zero;
    assign bus.out_illegal = s2_illegal;

    // Control decode: R-type uses funct7_5 for SUB/SRA, I-type only for SRAI
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        unique case (bus.alu_op)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            default: begin
                unique case (bus.funct3)
                    3'b000: dec_ctrl = (bus.alu_op == 2'b10 && bus.funct7_5) ? CTRL_SUB : CTRL_ADD;
                    3'b001: begin
                        dec_ctrl  = CTRL_SLL;
                        dec_shift = 1'b1;
                    end
                    3'b010: dec_ctrl = CTRL_SLT;
                    3'b011: dec_ctrl = CTRL_SLTU;
                    3'b100: dec_ctrl = CTRL_XOR;
                    3'b101: begin
                        dec_ctrl  = bus.funct7_5 ? CTRL_SRA : CTRL_SRL;
                        dec_shift = 1'b1;
                    end
                    3'b110: dec_ctrl = CTRL_OR;
                    default: dec_ctrl = CTRL_AND;
                endcase
                // R-type only has alternate encodings for ADD/SUB and SRL/SRA
                if (bus.alu_op == 2'b10 && bus.funct7_5 &&
                    bus.funct3 != 3'b000 && bus.funct3 != 3'b101) begin
                    dec_illegal = 1'b1;
                end
            end
        endcase
        if (dec_shift && !SHIFT_EN) begin
            dec_illegal = 1'b1;
        end
        // illegal requests report ADD so downstream sees a benign opcode
        if (dec_illegal) begin
            dec_ctrl = CTRL_ADD;
        end
    end

    assign shamt = s1_q.b[SHW-1:0];
    assign lt_s  = $signed(s1_q.a) < $signed(s1_q.b);
    assign lt_u  = s1_q.a < s1_q.b;

    // Execute on the S1 operands; illegal requests are forced to a zero result
    always_comb begin
        exe_result = '0;
        unique case (s1_q.ctrl)
            CTRL_AND:  exe_result = s1_q.a & s1_q.b;
            CTRL_OR:   exe_result = s1_q.a | s1_q.b;
            CTRL_ADD:  exe_result = s1_q.a + s1_q.b;
            CTRL_XOR:  exe_result = s1_q.a ^ s1_q.b;
            CTRL_SLL:  exe_result = s1_q.a << shamt;
            CTRL_SRL:  exe_result = s1_q.a >> shamt;
            CTRL_SUB:  exe_result = s1_q.a - s1_q.b;
            CTRL_SRA:  exe_result = $unsigned($signed(s1_q.a) >>> shamt);
            CTRL_SLT:  exe_result = {{(XLEN-1){1'b0}}, lt_s};
            CTRL_SLTU: exe_result = {{(XLEN-1){1'b0}}, lt_u};
            default:   exe_result = '0;
        endcase
        if (s1_q.illegal) begin
            exe_result = '0;
        end
    end

    // S1: capture decoded request; valid drops only when it advances with nothing behind it
    always_ff @(posedge clk) begin
        if (res) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (in_acc) begin
            s1_vld       <= 1'b1;
            s1_q.ctrl    <= dec_ctrl;
            s1_q.illegal <= dec_illegal;
            s1_q.a       <= bus.op_a;
            s1_q.b       <= bus.op_b;
        end else if (s2_load) begin
            s1_vld <= 1'b0;
        end
    end

    // S2: register the executed result; hold everything while stalled
    always_ff @(posedge clk) begin
        if (res) begin
            s2_vld     <= 1'b0;
            s2_ctrl    <= '0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s2_load) begin
            s2_vld     <= 1'b1;
            s2_ctrl    <= s1_q.ctrl;
            s2_result  <= exe_result;
            s2_zero    <= (exe_result == '0);
            s2_illegal <= s1_q.illegal;
        end else if (bus.out_ready) begin
            s2_vld <= 1'b0;
        end
    end
endmodule
